soc_system_flag_pulse_pio: RTL
==============================

SOC_SYSTEM_FLAG_PULSE_PIO -- requirements
Module: soc_system_flag_pulse_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning output flag count (1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 1, meaning DATA value after reset (low WIDTH bits used).
REQ-003 SHALL have parameter CNT_W, default 16, meaning pulse-length counter width (1..31).
REQ-004 SHALL have parameter LEN_RESET, default 1, meaning PULSE_LEN value after reset.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port address  input  3  Avalon-MM word offset.
REQ-008 SHALL have port chipselect  input  1  slave select.
REQ-009 SHALL have port write_n  input  1  active-low write; wr_strobe = chipselect & ~write_n.
REQ-010 SHALL have port writedata  input  32  write data; bits above WIDTH (or CNT_W for PULSE_LEN) ignored.
REQ-011 SHALL have port readdata  output  32  combinational read mux, zero-extended, no read latency, ignores chipselect.
REQ-012 SHALL have port out_port  output  WIDTH  registered flag outputs, equal to DATA.

Function
REQ-013 Register map SHALL be: 0 DATA rw; 1 PULSE_MASK rw; 2 PULSE_LEN rw; 3 ACTIVE ro; 4 SET wo; 5 CLR wo; 6 TOGGLE wo; 7 reserved.
REQ-014 Reads of 4, 5, 6, 7 SHALL return 0; writes to 3 and 7 SHALL have no effect.
REQ-015 Write 0 SHALL load DATA; write 4 SHALL OR into DATA; write 5 SHALL clear DATA bits where writedata=1; write 6 SHALL invert DATA bits where writedata=1; all take effect at the clock edge of the strobe cycle.
REQ-016 A DATA bit with PULSE_MASK=1 SHALL be in pulse mode: any write (0/4/6) leaving it 1 after being 0, or a SET (4) hitting an already-1 bit, SHALL load its counter with PULSE_LEN (0 treated as 1) and mark it ACTIVE.
REQ-017 While ACTIVE, the counter SHALL decrement each cycle; on the cycle it reads 1 the DATA bit and ACTIVE bit SHALL clear at the next edge, so out_port is high for exactly PULSE_LEN cycles (min 1).
REQ-018 A write that clears an ACTIVE bit (0/5/6) SHALL clear DATA and ACTIVE immediately; a write (0/6) leaving an ACTIVE bit 1 without retrigger per REQ-016 SHALL not reload the counter.
REQ-019 If a write and counter expiry coincide on the same bit, the write result SHALL win (including retrigger).
REQ-020 Clearing a PULSE_MASK bit SHALL clear its ACTIVE bit and counter; DATA bit SHALL keep its current value (level mode).
REQ-021 Changing PULSE_LEN SHALL affect only subsequently loaded counters.
REQ-022 Level-mode bits (PULSE_MASK=0) SHALL never change except by writes.

Reset
REQ-023 On reset_n low, asynchronously: DATA=RESET_VALUE, PULSE_MASK=0, PULSE_LEN=LEN_RESET, ACTIVE=0, all counters=0; out_port=RESET_VALUE.
REQ-024 Reset mid-pulse SHALL abort the pulse; no pulse SHALL resume after release.

Structure
REQ-025 Register offsets (0..7) and the default parameter values SHALL live in shared package soc_system_flag_pio_pkg.
REQ-026 Per-bit countdown SHALL be sub-module soc_system_flag_pulse_timer (load, cancel, len in; active, expire out), instantiated WIDTH times by generate.

Verification
REQ-027 Reset release -> out_port=4'b0001, readdata(addr2)=1, readdata(addr1)=0, readdata(addr3)=0.
REQ-028 Write SET=0x6, then CLR=0x2, then TOGGLE=0x9, all level mode -> out_port 0111, 0101, 1100.
REQ-029 PULSE_MASK=0x2, PULSE_LEN=5, SET=0x2 -> bit1 high exactly 5 cycles, ACTIVE bit1 readable during, then both 0.
REQ-030 Pulse as REQ-029, SET=0x2 again at cycle 3 of pulse -> bit1 stays high 5 cycles from the second write (8 total); CLR=0x2 mid-pulse -> low next cycle, ACTIVE=0.
REQ-031 PULSE_LEN=0, pulse bit set -> 1-cycle pulse; PULSE_LEN=65535 (CNT_W=16) -> 65535-cycle pulse, no wrap.
REQ-032 Assert reset_n low during a pulse -> out_port=RESET_VALUE immediately; after release bit stays at reset value, ACTIVE=0.

Source files
------------

// File: rtl/soc_system_flag_pio_pkg.sv
// rtl/soc_system_flag_pio_pkg.sv - register offsets and default parameters for the flag/pulse PIO
package soc_system_flag_pio_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_RESET_VALUE = 1;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_LEN_RESET   = 1;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_LEN    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE = 3'd6;
    localparam logic [2:0] ADDR_RSVD   = 3'd7;

endpackage

// File: rtl/soc_system_flag_pulse_timer.sv
// rtl/soc_system_flag_pulse_timer.sv - per-flag pulse countdown with load/cancel
module soc_system_flag_pulse_timer
    import soc_system_flag_pio_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             cancel,
    input  logic [CNT_W-1:0] len,
    output logic             active,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Last counted cycle: the owning flag drops at the next edge
    assign expire = active && (cnt == CNT_W'(1));

    // Cancel beats load, load beats countdown; a zero length behaves as one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (cancel) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= (len == '0) ? CNT_W'(1) : len;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == CNT_W'(1)) begin
                cnt    <= '0;
                active <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/soc_system_flag_pulse_pio.sv
// rtl/soc_system_flag_pulse_pio.sv - Avalon-MM flag PIO with per-bit level or timed pulse mode
module soc_system_flag_pulse_pio
    import soc_system_flag_pio_pkg::*;
#(
    parameter int          WIDTH       = DEF_WIDTH,
    parameter logic [31:0] RESET_VALUE = DEF_RESET_VALUE,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int          LEN_RESET   = DEF_LEN_RESET
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_strobe;
    logic             wr_data, wr_mask, wr_len, wr_set, wr_clr, wr_tog;
    logic             data_written;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data, mask, active, expire;
    logic [WIDTH-1:0] data_wr, rise, retrig, load, cancel, mask_clr;
    logic [CNT_W-1:0] pulse_len;
    logic             unused_wd;

    assign unused_wd = ^writedata;

    assign wr_strobe = chipselect & ~write_n;
    assign wr_data   = wr_strobe && (address == ADDR_DATA);
    assign wr_mask   = wr_strobe && (address == ADDR_MASK);
    assign wr_len    = wr_strobe && (address == ADDR_LEN);
    assign wr_set    = wr_strobe && (address == ADDR_SET);
    assign wr_clr    = wr_strobe && (address == ADDR_CLR);
    assign wr_tog    = wr_strobe && (address == ADDR_TOGGLE);
    assign data_written = wr_data | wr_set | wr_clr | wr_tog;
    assign wd = writedata[WIDTH-1:0];

    // DATA value the current write would produce
    always_comb begin
        data_wr = data;
        if (wr_data)     data_wr = wd;
        else if (wr_set) data_wr = data | wd;
        else if (wr_clr) data_wr = data & ~wd;
        else if (wr_tog) data_wr = data ^ wd;
    end

    // Start a pulse on a 0->1 write, or restart it when SET hits a bit already high
    assign rise     = {WIDTH{data_written}} & ~data & data_wr;
    assign retrig   = {WIDTH{wr_set}} & data & wd;
    assign load     = mask & (rise | retrig);
    assign mask_clr = {WIDTH{wr_mask}} & ~wd;
    assign cancel   = mask_clr | ({WIDTH{data_written}} & ~data_wr);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_timer
            soc_system_flag_pulse_timer #(
                .CNT_W (CNT_W)
            ) u_timer (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (load[gi]),
                .cancel  (cancel[gi]),
                .len     (pulse_len),
                .active  (active[gi]),
                .expire  (expire[gi])
            );
        end
    endgenerate

    // Writes win over expiry; a mask clear in the expiry cycle keeps the bit as a level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE[WIDTH-1:0];
        end else if (data_written) begin
            data <= data_wr;
        end else begin
            data <= data & ~(expire & ~mask_clr);
        end
    end

    // Mode mask and pulse length registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask      <= '0;
            pulse_len <= CNT_W'(LEN_RESET);
        end else begin
            if (wr_mask) mask      <= wd;
            if (wr_len)  pulse_len <= writedata[CNT_W-1:0];
        end
    end

    assign out_port = data;

    // Zero-latency read mux, independent of chipselect
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data);
            ADDR_MASK:   readdata = 32'(mask);
            ADDR_LEN:    readdata = 32'(pulse_len);
            ADDR_ACTIVE: readdata = 32'(active);
            default:     readdata = '0;
        endcase
    end

endmodule
